// File: rtl/mux_3to1.sv
// Registered 3-input word multiplexer: selects A/B/C under S and presents the
// choice on Y one clock later. Reserved code S=3 yields an all-zero word.
module mux_3to1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] sel;

  // Select decode; the default arm covers the reserved code 2'b11.
  always_comb begin
    sel = '0;
    case (S)
      2'b00:   sel = A;
      2'b01:   sel = B;
      2'b10:   sel = C;
      default: sel = '0;
    endcase
  end

  // No enable: the register loads every cycle, reset wins over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y <= '0;
    end else begin
      Y <= sel;
    end
  end

endmodule

// File: tb/tb_mux_3to1.sv
// Directed and randomized bench for mux_3to1 at WIDTH=32 and WIDTH=8, checked
// with immediate assertions against a table-lookup reference model.
module tb_mux_3to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, c, y;
  logic [1:0]  s;
  logic [7:0]  a8, b8, c8, y8;
  logic [1:0]  s8;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sweep_exp[4];
  logic [7:0]  sweep8_exp[4];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  mux_3to1 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .S(s), .Y(y)
  );

  mux_3to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .S(s8), .Y(y8)
  );

  // Reference: the decode table as an indexed word list, slot 3 reserved as zero.
  function automatic logic [31:0] model(input logic [1:0] sel_code,
                                        input logic [31:0] x0,
                                        input logic [31:0] x1,
                                        input logic [31:0] x2);
    logic [31:0] words[4];
    words[0] = x0;
    words[1] = x1;
    words[2] = x2;
    words[3] = 32'h0;
    return words[sel_code];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep_exp[0]  = 32'hDEAD_BEEF;
    sweep_exp[1]  = 32'h0123_4567;
    sweep_exp[2]  = 32'hFFFF_0000;
    sweep_exp[3]  = 32'h0000_0000;
    sweep8_exp[0] = 8'hA5;
    sweep8_exp[1] = 8'h5A;
    sweep8_exp[2] = 8'hFF;
    sweep8_exp[3] = 8'h00;

    rst = 1'b1;
    a = 32'h1111_1111; b = 32'h2222_2222; c = 32'h3333_3333; s = 2'd0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; s8 = 2'd0;

    // Reset held for two edges.
    step();
    check("reset_edge1", y, 32'h0);
    check("reset8_edge1", {24'h0, y8}, 32'h0);
    step();
    check("reset_edge2", y, 32'h0);
    check("reset8_edge2", {24'h0, y8}, 32'h0);

    // Select sweep with held data.
    rst = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; c = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      step();
      check($sformatf("sweep_s%0d", i), y, sweep_exp[i]);
    end

    // Latency: a select change is invisible until the next edge.
    s = 2'd0;
    step();
    check("lat_a", y, 32'hDEAD_BEEF);
    s = 2'd1;
    #3;
    check("lat_hold_sel", y, 32'hDEAD_BEEF);
    a = 32'h5555_AAAA;
    #2;
    check("lat_hold_data", y, 32'hDEAD_BEEF);
    step();
    check("lat_b", y, 32'h0123_4567);

    // Reset mid-stream discards the in-flight value.
    s = 2'd2; c = 32'hCAFE_F00D;
    step();
    check("mid_pre", y, 32'hCAFE_F00D);
    rst = 1'b1;
    step();
    check("mid_rst", y, 32'h0);
    rst = 1'b0;
    step();
    check("mid_release", y, 32'hCAFE_F00D);

    // Random data, S cycling through all codes, occasional reset pulses.
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      s = 2'(i % 4);
      rst = ($urandom_range(0, 7) == 0);
      exp_q.push_back(rst ? 32'h0 : model(s, a, b, c));
      step();
      exp_v = exp_q.pop_front();
      check($sformatf("rand_%0d_s%0d", i, i % 4), y, exp_v);
    end
    rst = 1'b0;

    // Narrow instance sweep.
    a8 = 8'hA5; b8 = 8'h5A; c8 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      s8 = 2'(i);
      step();
      check($sformatf("w8_s%0d", i), {24'h0, y8}, {24'h0, sweep8_exp[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
